// File: rtl/control_sequencer_if.sv
// Datapath control bus between control_sequencer (master) and the single-bus Datapath (slave).
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic        PCout, Zhiout, Zlowout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  ALU_op;
    logic        Run;
    logic        Illegal_op;
    logic        Bus_err;

    modport master (
        input  IR, Mem_ready, Stop,
        output PCout, Zhiout, Zlowout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output ALU_op, Run, Illegal_op, Bus_err
    );

    modport slave (
        output IR, Mem_ready, Stop,
        input  PCout, Zhiout, Zlowout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  ALU_op, Run, Illegal_op, Bus_err
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch/decode/execute of ALU, MUL/DIV, NOP and HALT.
// Optional macro SINGLE_STEP_EN adds a Step input gating the advance out of T0.
module control_sequencer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int OPW         = 5
) (
    input  logic                 Clock,
    input  logic                 Clear,
`ifdef SINGLE_STEP_EN
    input  logic                 Step,
`endif
    control_sequencer_if.master  bus
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [3:0] {
        S_T0, S_F1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_FAULT
    } state_t;

    typedef enum logic [2:0] {OC_ALU, OC_MD, OC_NOP, OC_HALT, OC_ILL} opcls_t;

    typedef struct packed {
        logic pc_out, zhi_out, zlo_out, mdr_out;
        logic mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
        logic inc_pc, read, gra, grb, grc, r_in, r_out;
    } ctl_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ill_q, ill_nxt, berr_q, berr_nxt;
    ctl_t             c, cg;
    logic             run;
    logic [OPW-1:0]   op, alu_op;
    opcls_t           cls;

    function automatic opcls_t classify(input logic [OPW-1:0] o);
        case (o)
            OPW'(3), OPW'(4), OPW'(5), OPW'(6),
            OPW'(7), OPW'(8), OPW'(9), OPW'(10): return OC_ALU;
            OPW'(15), OPW'(16):                  return OC_MD;
            OPW'(26):                            return OC_NOP;
            OPW'(27):                            return OC_HALT;
            default:                             return OC_ILL;
        endcase
    endfunction

    // IR only matters from T3 on; IRin fires in T2 so it is stable there.
    assign op  = bus.IR[31 -: OPW];
    assign cls = classify(op);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= S_T0;
            cnt    <= '0;
            ill_q  <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ill_q  <= ill_nxt;
            berr_q <= berr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        ill_nxt   = ill_q;
        berr_nxt  = berr_q;
        c         = '0;
        run       = 1'b1;
        alu_op    = '0;
        case (state)
            S_T0: begin
                c.pc_out  = 1'b1;
                c.mar_in  = 1'b1;
                c.inc_pc  = 1'b1;
                c.z_in    = 1'b1;
                state_nxt = bus.Stop ? S_HALTED : S_F1;
`ifdef SINGLE_STEP_EN
                if (!Step) begin
                    c         = '0;
                    run       = 1'b0;
                    state_nxt = S_T0;
                end
`endif
            end
            S_F1: begin
                c.read   = 1'b1;
                c.mdr_in = 1'b1;
                // cnt is zero only on the first FETCH1 cycle, so PC is written once
                c.pc_in   = (cnt == '0);
                c.zlo_out = (cnt == '0);
                if (bus.Mem_ready) begin
                    state_nxt = S_T2;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_nxt = S_FAULT;
                    berr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                case (cls)
                    OC_ALU:  begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; state_nxt = S_T4; end
                    OC_MD:   begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; state_nxt = S_T4; end
                    OC_NOP:  state_nxt = S_T0;
                    OC_HALT: state_nxt = S_HALTED;
                    default: begin ill_nxt = 1'b1; state_nxt = S_FAULT; end
                endcase
            end
            S_T4: begin
                state_nxt = S_T5;
                if (cls == OC_ALU) begin
                    c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu_op = op;
                end else if (cls == OC_MD) begin
                    c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu_op = op;
                end else begin
                    state_nxt = S_T0;
                end
            end
            S_T5: begin
                state_nxt = S_T0;
                if (cls == OC_ALU) begin
                    c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end else if (cls == OC_MD) begin
                    c.zlo_out = 1'b1; c.lo_in = 1'b1; state_nxt = S_T6;
                end
            end
            S_T6: begin
                c.zhi_out = 1'b1;
                c.hi_in   = 1'b1;
                state_nxt = S_T0;
            end
            S_HALTED, S_FAULT: run = 1'b0;
            default: state_nxt = S_T0;
        endcase
    end

    // Strobes are forced low while Clear is held, so an abort kills writes at once.
    assign cg = Clear ? c : '0;

    assign bus.PCout      = cg.pc_out;
    assign bus.Zhiout     = cg.zhi_out;
    assign bus.Zlowout    = cg.zlo_out;
    assign bus.MDRout     = cg.mdr_out;
    assign bus.MARin      = cg.mar_in;
    assign bus.PCin       = cg.pc_in;
    assign bus.MDRin      = cg.mdr_in;
    assign bus.IRin       = cg.ir_in;
    assign bus.Yin        = cg.y_in;
    assign bus.Zin        = cg.z_in;
    assign bus.HIin       = cg.hi_in;
    assign bus.LOin       = cg.lo_in;
    assign bus.IncPC      = cg.inc_pc;
    assign bus.Read       = cg.read;
    assign bus.Gra        = cg.gra;
    assign bus.Grb        = cg.grb;
    assign bus.Grc        = cg.grc;
    assign bus.Rin        = cg.r_in;
    assign bus.Rout       = cg.r_out;
    assign bus.ALU_op     = Clear ? 5'(alu_op) : 5'd0;
    assign bus.Run        = run;
    assign bus.Illegal_op = ill_q;
    assign bus.Bus_err    = berr_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer with a per-cycle expected-output scoreboard.
module tb_control_sequencer;
  localparam int TMO = 16;

  logic Clock = 1'b0;
  logic Clear = 1'b0;

  control_sequencer_if ifc();

  control_sequencer #(.TIMEOUT_CYC(TMO), .OPW(5)) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus  (ifc)
  );

  always #5 Clock = ~Clock;

  // Observed word: {Illegal_op, Bus_err, Run, ALU_op[4:0], 19 strobes}
  localparam logic [26:0] ILL    = 27'd1 << 26;
  localparam logic [26:0] BERR   = 27'd1 << 25;
  localparam logic [26:0] RUN    = 27'd1 << 24;
  localparam logic [26:0] PCOUT  = 27'd1 << 18;
  localparam logic [26:0] ZHIOUT = 27'd1 << 17;
  localparam logic [26:0] ZLOOUT = 27'd1 << 16;
  localparam logic [26:0] MDROUT = 27'd1 << 15;
  localparam logic [26:0] MARIN  = 27'd1 << 14;
  localparam logic [26:0] PCIN   = 27'd1 << 13;
  localparam logic [26:0] MDRIN  = 27'd1 << 12;
  localparam logic [26:0] IRIN   = 27'd1 << 11;
  localparam logic [26:0] YIN    = 27'd1 << 10;
  localparam logic [26:0] ZIN    = 27'd1 << 9;
  localparam logic [26:0] HIIN   = 27'd1 << 8;
  localparam logic [26:0] LOIN   = 27'd1 << 7;
  localparam logic [26:0] INCPC  = 27'd1 << 6;
  localparam logic [26:0] READ   = 27'd1 << 5;
  localparam logic [26:0] GRA    = 27'd1 << 4;
  localparam logic [26:0] GRB    = 27'd1 << 3;
  localparam logic [26:0] GRC    = 27'd1 << 2;
  localparam logic [26:0] RIN    = 27'd1 << 1;
  localparam logic [26:0] ROUT   = 27'd1 << 0;
  localparam logic [26:0] T0W    = RUN | PCOUT | MARIN | INCPC | ZIN;

  typedef enum int {K_ALU, K_MD, K_NOP, K_HALT, K_ILL} kind_t;
  typedef struct {
    logic [31:0] ir;
    int          waits;
    bit          stop;
    kind_t       kind;
  } vec_t;

  vec_t        vecs[12];
  logic [26:0] exq[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [26:0] sample();
    return {ifc.Illegal_op, ifc.Bus_err, ifc.Run, ifc.ALU_op,
            ifc.PCout, ifc.Zhiout, ifc.Zlowout, ifc.MDRout,
            ifc.MARin, ifc.PCin, ifc.MDRin, ifc.IRin, ifc.Yin, ifc.Zin, ifc.HIin, ifc.LOin,
            ifc.IncPC, ifc.Read, ifc.Gra, ifc.Grb, ifc.Grc, ifc.Rin, ifc.Rout};
  endfunction

  task automatic check(input string nm, input logic [26:0] exp);
    logic [26:0] act;
    act = sample();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic bit is_terminal(input vec_t v);
    return v.stop || v.waits >= TMO || v.kind == K_HALT || v.kind == K_ILL;
  endfunction

  // Expected per-cycle words for one instruction, starting at its T0.
  function automatic void model(input vec_t v);
    logic [26:0] opw;
    int nf;
    opw = 27'(v.ir[31:27]) << 19;
    exq.push_back(T0W);
    if (v.stop) begin
      repeat (3) exq.push_back(27'd0);
      return;
    end
    nf = (v.waits >= TMO) ? TMO : v.waits + 1;
    for (int i = 0; i < nf; i++)
      exq.push_back(RUN | READ | MDRIN | ((i == 0) ? (PCIN | ZLOOUT) : 27'd0));
    if (v.waits >= TMO) begin
      repeat (3) exq.push_back(BERR);
      return;
    end
    exq.push_back(RUN | MDROUT | IRIN);
    case (v.kind)
      K_ALU: begin
        exq.push_back(RUN | GRB | ROUT | YIN);
        exq.push_back(RUN | GRC | ROUT | ZIN | opw);
        exq.push_back(RUN | ZLOOUT | GRA | RIN);
      end
      K_MD: begin
        exq.push_back(RUN | GRA | ROUT | YIN);
        exq.push_back(RUN | GRB | ROUT | ZIN | opw);
        exq.push_back(RUN | ZLOOUT | LOIN);
        exq.push_back(RUN | ZHIOUT | HIIN);
      end
      K_NOP:  exq.push_back(RUN);
      K_HALT: begin exq.push_back(RUN); repeat (3) exq.push_back(27'd0); end
      default: begin exq.push_back(RUN); repeat (3) exq.push_back(ILL); end
    endcase
  endfunction

  // Entered and left at a falling edge with the DUT in T0.
  task automatic run_vec(input vec_t v, input string nm, input int abort_at);
    int k;
    logic [26:0] exp;
    model(v);
    ifc.IR   = v.ir;
    ifc.Stop = v.stop;
    k = 0;
    while (exq.size() > 0) begin
      exp = exq.pop_front();
      #1 check($sformatf("%s_c%0d", nm, k), exp);
      if (k == abort_at) begin
        Clear = 1'b0;
        #1 check($sformatf("%s_abort", nm), RUN);
        exq.delete();
        @(negedge Clock);
        Clear = 1'b1;
        return;
      end
      ifc.Mem_ready = (k > v.waits);
      k++;
      @(negedge Clock);
    end
    if (is_terminal(v)) begin
      Clear = 1'b0;
      #1 check($sformatf("%s_clr", nm), RUN);
      @(negedge Clock);
      Clear    = 1'b1;
      ifc.Stop = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h3A92_0000,            0, 1'b0, K_ALU};  // shr R5,R2,R4
    vecs[1]  = '{{5'b00011, 27'h0123456}, 3, 1'b0, K_ALU};  // add, 3 wait states
    vecs[2]  = '{{5'b01111, 27'h0000400}, 0, 1'b0, K_MD};   // mul
    vecs[3]  = '{{5'b10000, 27'h7FFFFFF}, 1, 1'b0, K_MD};   // div
    vecs[4]  = '{{5'b11010, 27'h0},       0, 1'b0, K_NOP};
    vecs[5]  = '{{5'b01010, 27'h0001111}, 15, 1'b0, K_ALU}; // ready on last allowed cycle
    vecs[6]  = '{{5'b00101, 27'h0},       0, 1'b0, K_ALU};  // and
    vecs[7]  = '{{5'b11111, 27'h0},       0, 1'b0, K_ILL};
    vecs[8]  = '{{5'b11011, 27'h0},       0, 1'b0, K_HALT};
    vecs[9]  = '{{5'b00011, 27'h0},       0, 1'b1, K_ALU};  // Stop at T0
    vecs[10] = '{{5'b00100, 27'h0},       99, 1'b0, K_ALU}; // fetch timeout
    vecs[11] = '{{5'b00000, 27'h0},       0, 1'b0, K_ILL};

    ifc.IR        = '0;
    ifc.Mem_ready = 1'b0;
    ifc.Stop      = 1'b0;
    repeat (2) @(negedge Clock);
    #1 check("reset", RUN);
    @(negedge Clock);
    Clear = 1'b1;

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i], $sformatf("v%0d", i), -1);

    // Async abort in the middle of T4, then a clean restart.
    run_vec('{{5'b00110, 27'h0}, 0, 1'b0, K_ALU}, "abortT4", 4);
    run_vec('{{5'b11010, 27'h0}, 0, 1'b0, K_NOP}, "after_abort", -1);
    run_vec('{{5'b01001, 27'h0}, 2, 1'b0, K_ALU}, "ror", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives the existing single-bus Datapath through fetch and execute of register-register ALU, MUL/DIV, NOP and HALT instructions.
- Replaces testbench-driven control sequences: every Datapath strobe (PCout, Zlowout, MDRin, Yin, Zin, ...) comes from this block.
- Register selection uses Gra/Grb/Grc plus Rin/Rout for the Datapath's select-and-encode logic.
- Waits on a memory ready handshake during fetch and flags bus timeouts.

Parameters:
- TIMEOUT_CYC, 16: max cycles in FETCH1 waiting for Mem_ready before Bus_err.
- OPW, 5: opcode width, taken from IR[31:27].

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous active-low reset.
- IR  in  32  instruction register contents from the Datapath.
- Mem_ready  in  1  memory read data valid, sampled in FETCH1.
- Stop  in  1  halt request, honoured only at the T0 boundary.
- PCout, Zhiout, Zlowout, MDRout  out  1 each  Datapath bus drivers.
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  Datapath register enables.
- IncPC, Read  out  1 each  PC increment; memory read strobe.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register select/encode controls.
- ALU_op  out  5  opcode presented to the ALU; 0 outside T4.
- Run  out  1  high while fetching or executing.
- Illegal_op  out  1  sticky flag: undefined opcode.
- Bus_err  out  1  sticky flag: fetch timeout.

Behaviour:
- State register is reset asynchronously when Clear=0; the state on release is T0.
- All outputs decode combinationally from the state register only (Moore). Each state lasts exactly 1 clock unless stated otherwise.
- Reset values: every strobe 0, ALU_op=0, Run=1, Illegal_op=0, Bus_err=0, timeout counter=0.
- Opcodes:
  - ALU group: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol.
  - 01111 mul, 10000 div.
  - 11010 nop, 11011 halt.
  - Any other value is illegal.
- T0: PCout, MARin, IncPC, Zin. Next state is HALTED if Stop=1, else FETCH1.
- FETCH1: Read, MDRin, Zlowout, PCin.
  - PCin and Zlowout assert only in the first FETCH1 cycle, so PC is written once.
  - Read and MDRin stay high while waiting.
  - Mem_ready=1 -> T2; the counter clears.
  - Mem_ready=0 -> counter increments. When the counter reaches TIMEOUT_CYC-1, go to FAULT and set Bus_err.
- T2: MDRout, IRin. Next state is T3.
- T3, decode on IR[31:27]:
  - ALU group: Grb, Rout, Yin.
  - mul/div: Gra, Rout, Yin.
  - nop: no strobes; next state T0.
  - halt: next state HALTED.
  - Illegal: set Illegal_op; next state FAULT.
- T4:
  - ALU group: Grc, Rout, Zin, ALU_op=opcode.
  - mul/div: Grb, Rout, Zin, ALU_op=opcode.
- T5:
  - ALU group: Zlowout, Gra, Rin; next state T0.
  - mul/div: Zlowout, LOin; next state T6.
- T6 (mul/div only): Zhiout, HIin; next state T0.
- HALTED and FAULT: all strobes 0, Run=0. Both states are held until Clear.
- IR is sampled only in states T3–T6. It is stable there because IRin fires only in T2.
- Latency in clocks, with zero-wait memory: ALU op 6, mul/div 7, nop 4.
- Simultaneous events:
  - Stop during a non-T0 state is ignored until the next T0 evaluation. The bench must hold Stop until Run falls.
  - Clear low mid-instruction aborts immediately; the partial register write is lost.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined, adds input Step (1 bit).
- From T0, the FSM advances only on a cycle with Step=1. Otherwise it holds T0 with all strobes 0 and Run=0.
- Not defined: no Step port; T0 advances every cycle as above.

Test Plan:
- Each scenario lists stimulus -> required response.
- Scenario 1, SHR decode: IR=0x3A920000 (shr R5,R2,R4), Mem_ready=1 -> sequence T0,F1,T2,T3,T4,T5.
  - T3: Grb+Rout+Yin.
  - T4: Grc+Rout+Zin, ALU_op=5'b00111.
  - T5: Gra+Rin+Zlowout.
  - Back in T0 on clock 7.
- Scenario 2, MUL: IR opcode 01111 -> T5 asserts LOin+Zlowout, T6 asserts HIin+Zhiout; Rin never asserted.
- Scenario 3, wait states: Mem_ready low for 3 cycles -> FETCH1 held 4 clocks; PCin high in the first only; Read continuous; no Bus_err.
- Scenario 4, timeout: Mem_ready held 0, TIMEOUT_CYC=16 -> Bus_err=1 and Run=0 after 16 FETCH1 cycles; both held until Clear pulses low.
- Scenario 5, illegal and halt:
  - Opcode 11111 -> Illegal_op=1 and FAULT after T3.
  - Opcode 11011 -> Run=0 with no flags.
  - Stop=1 at T0 -> HALTED without fetch (Read never asserts).
- Scenario 6, reset mid-T4: Clear=0 asynchronously -> all strobes 0 within the same cycle; on release the FSM restarts at T0. With SINGLE_STEP_EN, it waits for Step.
